// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// master drives the stream and start; slave is the loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words;

  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_data,
    input  cpu_rst, busy, done, err, words
  );

  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_data,
    output cpu_rst, busy, done, err, words
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian words from a length-prefixed byte stream into imem.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, COLLECT, WRITE,
    CHK, FINISH, DONE, ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] n;
  logic [15:0] idx;
  logic [1:0]  cnt;
  logic [23:0] acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        xfer;
  logic        load_req;
  logic        last;
  logic [15:0] n_new;

  assign bus.byte_ready = (state == LEN_HI)  |
                          (state == LEN_LO)  |
                          (state == COLLECT) |
                          (state == CHK);

  assign xfer  = bus.byte_valid & bus.byte_ready;
  assign n_new = {len_hi, bus.byte_data};
  assign last  = (idx + 16'd1) >= n;

  // start only counts when no load is running
  assign load_req = bus.start &
                    ((state == IDLE) | (state == DONE) | (state == ERROR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_hi       <= '0;
      n            <= '0;
      idx          <= '0;
      cnt          <= '0;
      acc          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.cpu_rst  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.words    <= '0;
    end else if (load_req) begin
      state       <= LEN_HI;
      idx         <= '0;
      cnt         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
      bus.busy    <= 1'b1;
      bus.cpu_rst <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.words   <= '0;
    end else begin
      unique case (state)
        LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.byte_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            n <= n_new;
            unique case (1'b1)
              (n_new == 16'd0): begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= FINISH;
`endif
              end
              (32'(n_new) > MAX_WORDS): begin
                state    <= ERROR;
                bus.busy <= 1'b0;
                bus.err  <= 1'b1;
              end
              default: state <= COLLECT;
            endcase
          end
        end
        COLLECT: begin
          if (xfer) begin
            acc <= {acc[15:0], bus.byte_data};
            cnt <= cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.byte_data;
`endif
            if (cnt == 2'd3) begin
              state        <= WRITE;
              bus.mem_we   <= 1'b1;
              bus.mem_addr <= BASE_ADDR + {14'd0, idx, 2'b00};
              bus.mem_data <= {acc, bus.byte_data};
            end
          end
        end
        WRITE: begin
          bus.mem_we <= 1'b0;
          bus.words  <= bus.words + 16'd1;
          idx        <= idx + 16'd1;
          if (!last) begin
            state <= COLLECT;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state <= FINISH;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            if (bus.byte_data == csum) begin
              state <= FINISH;
            end else begin
              state    <= ERROR;
              bus.busy <= 1'b0;
              bus.err  <= 1'b1;
            end
          end
        end
`endif
        FINISH: begin
          state       <= DONE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.cpu_rst <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
